// File: rtl/multiplier_n_bit_seq.sv
// Sequential radix-2 shift-add multiplier, unsigned or two's-complement.
// One partial product is accumulated per RUN cycle; the product is split
// into a low half (o_fu0) and a high half (o_fu1).
module multiplier_n_bit_seq #(
   parameter int WIDTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_signed,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_fu0,
   output logic [WIDTH-1:0] o_fu1
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int PW    = 2 * WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic             accept;
   logic             last_step;

   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic             neg;
   logic [CNT_W-1:0] cnt;
   logic [PW-1:0]    acc;
   logic [PW-1:0]    addend;
   logic [PW-1:0]    acc_step;
   logic [PW-1:0]    product;

   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic             neg_in;

   // Operand magnitudes; the most-negative value negates to 2^(WIDTH-1),
   // which is still exact as an unsigned WIDTH-bit number.
   assign a_mag  = (i_signed && i_a[WIDTH-1]) ? -i_a : i_a;
   assign b_mag  = (i_signed && i_b[WIDTH-1]) ? -i_b : i_b;
   assign neg_in = i_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);

   // The final step is folded into the result so RUN lasts exactly WIDTH cycles.
   assign last_step = (cnt == CNT_W'(WIDTH - 1));
   assign addend    = PW'(mcand) << cnt;
   assign acc_step  = mplier[0] ? (acc + addend) : acc;

   // State register; reset has priority over any request.
   always_ff @(posedge i_clk) begin
      // NOTE: sequential state is written with <= only, so every register
      // in this block samples the pre-edge values of the others.
      if (i_rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state, handshake outputs and accept strobe.
   always_comb begin
      // NOTE: every output of this block gets a default first; a path that
      // left one unassigned would infer a latch.
      state_next = state;
      o_busy     = 1'b0;
      o_done     = 1'b0;
      accept     = 1'b0;
      unique case (state)
         IDLE: begin
            if (i_start) begin
               state_next = RUN;
               accept     = 1'b1;
            end
         end
         RUN: begin
            o_busy = 1'b1;
            if (last_step) begin
               state_next = DONE;
            end
         end
         DONE: begin
            o_done = 1'b1;
            if (i_start) begin
               state_next = RUN;
               accept     = 1'b1;
            end else begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath: capture operands on accept, shift-add during RUN, publish on the last step.
   always_ff @(posedge i_clk) begin
      // NOTE: operand registers are reset along with the accumulator so the
      // datapath never holds stale values after reset; this is cheap at this size.
      if (i_rst) begin
         mcand   <= '0;
         mplier  <= '0;
         neg     <= 1'b0;
         cnt     <= '0;
         acc     <= '0;
         product <= '0;
      end else if (accept) begin
         mcand  <= a_mag;
         mplier <= b_mag;
         neg    <= neg_in;
         cnt    <= '0;
         acc    <= '0;
      end else if (state == RUN) begin
         acc    <= acc_step;
         mplier <= mplier >> 1;
         cnt    <= cnt + 1'b1;
         if (last_step) begin
            product <= neg ? -acc_step : acc_step;
         end
      end
   end

   assign o_fu0 = product[WIDTH-1:0];
   assign o_fu1 = product[PW-1:WIDTH];

endmodule

// File: tb/tb_multiplier_n_bit_seq.sv
// Directed bench for multiplier_n_bit_seq at WIDTH=4 and WIDTH=8.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_multiplier_n_bit_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       start4 = 1'b0;
   logic       signed4 = 1'b0;
   logic [3:0] a4 = '0;
   logic [3:0] b4 = '0;
   logic       busy4;
   logic       done4;
   logic [3:0] fu0_4;
   logic [3:0] fu1_4;

   logic       start8 = 1'b0;
   logic       signed8 = 1'b0;
   logic [7:0] a8 = '0;
   logic [7:0] b8 = '0;
   logic       busy8;
   logic       done8;
   logic [7:0] fu0_8;
   logic [7:0] fu1_8;

   int checks = 0;
   int errors = 0;

   logic [7:0]  prev4 = '0;
   logic [15:0] prev8 = '0;

   always #5 clk = ~clk;

   multiplier_n_bit_seq #(.WIDTH(4)) dut4 (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_start  (start4),
      .i_signed (signed4),
      .i_a      (a4),
      .i_b      (b4),
      .o_busy   (busy4),
      .o_done   (done4),
      .o_fu0    (fu0_4),
      .o_fu1    (fu1_4)
   );

   multiplier_n_bit_seq #(.WIDTH(8)) dut8 (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_start  (start8),
      .i_signed (signed8),
      .i_a      (a8),
      .i_b      (b8),
      .o_busy   (busy8),
      .o_done   (done8),
      .o_fu0    (fu0_8),
      .o_fu1    (fu1_8)
   );

   // One WIDTH=4 operation: o_done must be seen 5 falling edges after the
   // start was driven, for one cycle, with the product held afterwards.
   task automatic do_op4(input logic sgn, input logic [3:0] a, input logic [3:0] b,
                         input logic [7:0] exp, input string name);
      int   lat;
      logic seen;
      @(negedge clk);
      start4 = 1'b1; signed4 = sgn; a4 = a; b4 = b;
      lat = 0; seen = 1'b0;
      while (!seen && lat < 20) begin
         @(negedge clk);
         lat++;
         // Scramble inputs after the accept edge; they must have no effect.
         start4 = 1'b0; signed4 = ~sgn; a4 = ~a; b4 = ~b;
         if (lat == 1) begin
            checks++;
            if (busy4 !== 1'b1 || done4 !== 1'b0) begin
               errors++;
               $display("FAIL %s busy/done after accept: got %b/%b expected 1/0", name, busy4, done4);
            end
         end
         if (lat == 2) begin
            checks++;
            if ({fu1_4, fu0_4} !== prev4) begin
               errors++;
               $display("FAIL %s hold during RUN: got %h expected %h", name, {fu1_4, fu0_4}, prev4);
            end
         end
         if (done4 === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen || lat != 5) begin
         errors++;
         $display("FAIL %s done latency: got %0d (seen=%b) expected 5", name, lat, seen);
      end
      checks++;
      if ({fu1_4, fu0_4} !== exp || busy4 !== 1'b0) begin
         errors++;
         $display("FAIL %s product: got %h busy=%b expected %h busy=0", name, {fu1_4, fu0_4}, busy4, exp);
      end
      @(negedge clk);
      checks++;
      if (done4 !== 1'b0 || {fu1_4, fu0_4} !== exp) begin
         errors++;
         $display("FAIL %s pulse/hold: got done=%b %h expected done=0 %h", name, done4, {fu1_4, fu0_4}, exp);
      end
      prev4 = exp;
   endtask

   // One WIDTH=8 operation: o_done expected 9 falling edges after start.
   task automatic do_op8(input logic sgn, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp, input string name);
      int   lat;
      logic seen;
      @(negedge clk);
      start8 = 1'b1; signed8 = sgn; a8 = a; b8 = b;
      lat = 0; seen = 1'b0;
      while (!seen && lat < 30) begin
         @(negedge clk);
         lat++;
         start8 = 1'b0; signed8 = ~sgn; a8 = ~a; b8 = ~b;
         if (lat == 3) begin
            checks++;
            if ({fu1_8, fu0_8} !== prev8 || busy8 !== 1'b1) begin
               errors++;
               $display("FAIL %s hold during RUN: got %h busy=%b expected %h busy=1", name, {fu1_8, fu0_8}, busy8, prev8);
            end
         end
         if (done8 === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen || lat != 9) begin
         errors++;
         $display("FAIL %s done latency: got %0d (seen=%b) expected 9", name, lat, seen);
      end
      checks++;
      if ({fu1_8, fu0_8} !== exp) begin
         errors++;
         $display("FAIL %s product: got %h expected %h", name, {fu1_8, fu0_8}, exp);
      end
      @(negedge clk);
      checks++;
      if (done8 !== 1'b0) begin
         errors++;
         $display("FAIL %s pulse width: got done=%b expected 0", name, done8);
      end
      prev8 = exp;
   endtask

   task automatic test_reset;
      rst = 1'b1; start4 = 1'b1; start8 = 1'b1;
      repeat (2) @(negedge clk);
      // Reset and start were both high at the last edge: reset must win.
      checks++;
      if (busy4 !== 1'b0 || done4 !== 1'b0 || fu0_4 !== 4'h0 || fu1_4 !== 4'h0) begin
         errors++;
         $display("FAIL reset4: got busy=%b done=%b fu=%h%h expected 0 0 00", busy4, done4, fu1_4, fu0_4);
      end
      checks++;
      if (busy8 !== 1'b0 || done8 !== 1'b0 || fu0_8 !== 8'h0 || fu1_8 !== 8'h0) begin
         errors++;
         $display("FAIL reset8: got busy=%b done=%b fu=%h%h expected 0 0 0000", busy8, done8, fu1_8, fu0_8);
      end
      rst = 1'b0; start4 = 1'b0; start8 = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (busy4 !== 1'b0 || done4 !== 1'b0) begin
         errors++;
         $display("FAIL idle4: got busy=%b done=%b expected 0 0", busy4, done4);
      end
   endtask

   task automatic test_unsigned;
      do_op4(1'b0, 4'h0, 4'h0, 8'h00, "u0x0");
      do_op4(1'b0, 4'hF, 4'hF, 8'hE1, "u15x15");
      do_op4(1'b0, 4'hF, 4'h0, 8'h00, "u15x0");
      do_op4(1'b0, 4'h5, 4'h6, 8'h1E, "u5x6");
      repeat (3) @(negedge clk);
      checks++;
      if ({fu1_4, fu0_4} !== 8'h1E || done4 !== 1'b0) begin
         errors++;
         $display("FAIL idle hold: got %h done=%b expected 1e done=0", {fu1_4, fu0_4}, done4);
      end
   endtask

   task automatic test_signed;
      do_op4(1'b1, 4'hF, 4'hF, 8'h01, "s-1x-1");
      do_op4(1'b1, 4'h8, 4'h7, 8'hC8, "s-8x7");
      do_op4(1'b1, 4'h8, 4'h8, 8'h40, "s-8x-8");
      do_op4(1'b1, 4'h3, 4'hE, 8'hFA, "s3x-2");
   endtask

   task automatic test_start_ignored;
      int   lat;
      logic seen;
      @(negedge clk);
      start4 = 1'b1; signed4 = 1'b0; a4 = 4'h5; b4 = 4'h6;
      lat = 0; seen = 1'b0;
      while (!seen && lat < 20) begin
         @(negedge clk);
         lat++;
         if (lat == 2) begin
            start4 = 1'b1; signed4 = 1'b1; a4 = 4'hF; b4 = 4'h9;
         end else begin
            start4 = 1'b0;
         end
         if (done4 === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen || lat != 5 || {fu1_4, fu0_4} !== 8'h1E) begin
         errors++;
         $display("FAIL busy_start: got lat=%0d seen=%b %h expected lat=5 1e", lat, seen, {fu1_4, fu0_4});
      end
      @(negedge clk);
      checks++;
      if (busy4 !== 1'b0 || done4 !== 1'b0) begin
         errors++;
         $display("FAIL busy_start idle: got busy=%b done=%b expected 0 0", busy4, done4);
      end
      prev4 = 8'h1E;
   endtask

   task automatic test_back_to_back;
      int   lat;
      logic seen;
      logic [7:0] exp [2];
      exp[0] = 8'h0F;   // 3*5
      exp[1] = 8'h3F;   // 7*9
      @(negedge clk);
      start4 = 1'b1; signed4 = 1'b0; a4 = 4'h3; b4 = 4'h5;
      for (int op = 0; op < 2; op++) begin
         lat = 0; seen = 1'b0;
         while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat == 1 && busy4 !== 1'b1) begin
               errors++;
               $display("FAIL b2b%0d busy: got %b expected 1", op, busy4);
            end
            if (done4 === 1'b1) seen = 1'b1;
         end
         checks++;
         if (!seen || lat != 5 || {fu1_4, fu0_4} !== exp[op]) begin
            errors++;
            $display("FAIL b2b%0d: got lat=%0d seen=%b %h expected lat=5 %h", op, lat, seen, {fu1_4, fu0_4}, exp[op]);
         end
         if (op == 0) begin
            a4 = 4'h7; b4 = 4'h9;
         end else begin
            start4 = 1'b0;
         end
      end
      @(negedge clk);
      checks++;
      if (busy4 !== 1'b0 || done4 !== 1'b0) begin
         errors++;
         $display("FAIL b2b end: got busy=%b done=%b expected 0 0", busy4, done4);
      end
      prev4 = 8'h3F;
   endtask

   task automatic test_reset_mid_run;
      logic seen;
      @(negedge clk);
      start4 = 1'b1; signed4 = 1'b0; a4 = 4'hF; b4 = 4'hF;
      @(negedge clk);
      start4 = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (busy4 !== 1'b0 || done4 !== 1'b0 || {fu1_4, fu0_4} !== 8'h00) begin
         errors++;
         $display("FAIL mid_reset: got busy=%b done=%b %h expected 0 0 00", busy4, done4, {fu1_4, fu0_4});
      end
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done4 === 1'b1 || busy4 === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL mid_reset activity: got done/busy after reset expected none");
      end
      prev4 = 8'h00;
      prev8 = 16'h0000;
      do_op4(1'b0, 4'h2, 4'h3, 8'h06, "after_reset");
   endtask

   task automatic test_width8;
      do_op8(1'b0, 8'hFF, 8'hFF, 16'hFE01, "w8 255x255");
      do_op8(1'b1, 8'h80, 8'hFF, 16'h0080, "w8 -128x-1");
      do_op8(1'b1, 8'h7F, 8'h80, 16'hC080, "w8 127x-128");
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_start_ignored();
      test_back_to_back();
      test_reset_mid_run();
      test_width8();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
